// File: rtl/dac_sample_mixer_if.sv
`default_nettype none
// ============================================================================
// dac_sample_mixer_if : producer-side sample bus and DAC-side mixed output
// Revision 1.0
// ============================================================================
interface dac_sample_mixer_if #(
  parameter int NUM_SRC   = 2,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16
);
  logic [NUM_SRC-1:0]          src_valid;
  logic [NUM_SRC*IN_WIDTH-1:0] src_l;
  logic [NUM_SRC*IN_WIDTH-1:0] src_r;
  logic [NUM_SRC-1:0]          src_en;
  logic [NUM_SRC*3-1:0]        src_atten;
  logic                        sample_valid;
  logic [OUT_WIDTH-1:0]        sample_l;
  logic [OUT_WIDTH-1:0]        sample_r;
  logic                        clip;

  modport master (
    output src_valid, src_l, src_r, src_en, src_atten,
    input  sample_valid, sample_l, sample_r, clip
  );

  modport slave (
    input  src_valid, src_l, src_r, src_en, src_atten,
    output sample_valid, sample_l, sample_r, clip
  );
endinterface
`default_nettype wire

// File: rtl/dac_sample_mixer.sv
`default_nettype none
// ============================================================================
// dac_sample_mixer : fixed-rate saturating stereo mixer feeding the DAC path
// Revision 1.0
// ============================================================================
module dac_sample_mixer #(
  parameter int NUM_SRC     = 2,
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int CLK_DIV     = 1024,
  parameter int STALE_TICKS = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  dac_sample_mixer_if.slave bus
);
  localparam int ACC_W   = IN_WIDTH + $clog2(NUM_SRC) + 1;
  localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W   = $clog2(CLK_DIV);
  localparam int STALE_W = $clog2(STALE_TICKS + 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_SRC - 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_TICKS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_SAT   = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [IN_WIDTH-1:0] hold_l_q [NUM_SRC];
  logic signed [IN_WIDTH-1:0] hold_l_d [NUM_SRC];
  logic signed [IN_WIDTH-1:0] hold_r_q [NUM_SRC];
  logic signed [IN_WIDTH-1:0] hold_r_d [NUM_SRC];
  logic signed [IN_WIDTH-1:0] snap_l_q [NUM_SRC];
  logic signed [IN_WIDTH-1:0] snap_l_d [NUM_SRC];
  logic signed [IN_WIDTH-1:0] snap_r_q [NUM_SRC];
  logic signed [IN_WIDTH-1:0] snap_r_d [NUM_SRC];
  logic [STALE_W-1:0]         stale_q [NUM_SRC];
  logic [STALE_W-1:0]         stale_d [NUM_SRC];
  logic [STALE_W-1:0]         snap_stale_q [NUM_SRC];
  logic [STALE_W-1:0]         snap_stale_d [NUM_SRC];
  logic [OUT_WIDTH-1:0]       sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic                       sample_valid_q, sample_valid_d, clip_q, clip_d;

  logic                       tick;
  logic signed [IN_WIDTH-1:0] in_l [NUM_SRC];
  logic signed [IN_WIDTH-1:0] in_r [NUM_SRC];
  logic [2:0]                 atten [NUM_SRC];
  logic signed [ACC_W-1:0]    ext_l, ext_r, term_l, term_r;
  logic [OUT_WIDTH-1:0]       sat_l, sat_r;
  logic                       clip_nxt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign in_l[i]  = bus.src_l[i*IN_WIDTH +: IN_WIDTH];
    assign in_r[i]  = bus.src_r[i*IN_WIDTH +: IN_WIDTH];
    assign atten[i] = bus.src_atten[i*3 +: 3];
  end

  assign tick  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Snapshot sees pre-capture state; a coinciding capture still clears stale.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      hold_l_d[i]     = hold_l_q[i];
      hold_r_d[i]     = hold_r_q[i];
      stale_d[i]      = stale_q[i];
      snap_l_d[i]     = snap_l_q[i];
      snap_r_d[i]     = snap_r_q[i];
      snap_stale_d[i] = snap_stale_q[i];
      if (tick) begin
        snap_l_d[i]     = hold_l_q[i];
        snap_r_d[i]     = hold_r_q[i];
        snap_stale_d[i] = stale_q[i];
        if (stale_q[i] != STALE_MAX) stale_d[i] = stale_q[i] + 1'b1;
      end
      if (bus.src_valid[i]) begin
        hold_l_d[i] = in_l[i];
        hold_r_d[i] = in_r[i];
        stale_d[i]  = '0;
      end
    end
  end

  always_comb begin
    ext_l  = ACC_W'(snap_l_q[idx_q]);
    ext_r  = ACC_W'(snap_r_q[idx_q]);
    term_l = '0;
    term_r = '0;
    if (bus.src_en[idx_q] && (snap_stale_q[idx_q] < STALE_MAX)) begin
      term_l = ext_l >>> atten[idx_q];
      term_r = ext_r >>> atten[idx_q];
    end
  end

  if (OUT_WIDTH >= ACC_W) begin : g_wide
    assign sat_l    = OUT_WIDTH'(acc_l_q);
    assign sat_r    = OUT_WIDTH'(acc_r_q);
    assign clip_nxt = 1'b0;
  end else begin : g_clamp
    localparam logic signed [ACC_W-1:0] OUT_MAX =
      {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    // Returns {clipped, value}.
    function automatic logic [OUT_WIDTH:0] clamp(input logic signed [ACC_W-1:0] a);
      if (a > OUT_MAX) return {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
      if (a < OUT_MIN) return {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
      return {1'b0, a[OUT_WIDTH-1:0]};
    endfunction

    logic [OUT_WIDTH:0] cl_l, cl_r;
    assign cl_l     = clamp(acc_l_q);
    assign cl_r     = clamp(acc_r_q);
    assign sat_l    = cl_l[OUT_WIDTH-1:0];
    assign sat_r    = cl_r[OUT_WIDTH-1:0];
    assign clip_nxt = cl_l[OUT_WIDTH] | cl_r[OUT_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tick) state_d = ST_ACCUM;
      ST_ACCUM: if (idx_q == IDX_LAST) state_d = ST_SAT;
      ST_SAT:   state_d = ST_OUT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d          = idx_q;
    acc_l_d        = acc_l_q;
    acc_r_d        = acc_r_q;
    sample_valid_d = (state_q == ST_SAT);
    clip_d         = (state_q == ST_SAT) && clip_nxt;
    sample_l_d     = (state_q == ST_SAT) ? sat_l : sample_l_q;
    sample_r_d     = (state_q == ST_SAT) ? sat_r : sample_r_q;
    if (state_q == ST_IDLE && tick) begin
      idx_d   = '0;
      acc_l_d = '0;
      acc_r_d = '0;
    end else if (state_q == ST_ACCUM) begin
      acc_l_d = acc_l_q + term_l;
      acc_r_d = acc_r_q + term_r;
      if (idx_q != IDX_LAST) idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      acc_l_q        <= '0;
      acc_r_q        <= '0;
      sample_l_q     <= '0;
      sample_r_q     <= '0;
      sample_valid_q <= 1'b0;
      clip_q         <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_l_q[i]     <= '0;
        hold_r_q[i]     <= '0;
        snap_l_q[i]     <= '0;
        snap_r_q[i]     <= '0;
        stale_q[i]      <= STALE_MAX;
        snap_stale_q[i] <= STALE_MAX;
      end
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      acc_l_q        <= acc_l_d;
      acc_r_q        <= acc_r_d;
      sample_l_q     <= sample_l_d;
      sample_r_q     <= sample_r_d;
      sample_valid_q <= sample_valid_d;
      clip_q         <= clip_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_l_q[i]     <= hold_l_d[i];
        hold_r_q[i]     <= hold_r_d[i];
        snap_l_q[i]     <= snap_l_d[i];
        snap_r_q[i]     <= snap_r_d[i];
        stale_q[i]      <= stale_d[i];
        snap_stale_q[i] <= snap_stale_d[i];
      end
    end
  end

  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_l     = sample_l_q;
  assign bus.sample_r     = sample_r_q;
  assign bus.clip         = clip_q;

  // A mix pass must always finish before the next tick arrives.
  a_tick_in_idle: assert property (@(posedge clk) disable iff (reset)
    tick |-> (state_q == ST_IDLE));
endmodule
`default_nettype wire

// File: tb/tb_dac_sample_mixer.sv
`default_nettype none
// ============================================================================
// tb_dac_sample_mixer : directed and random checks against a behavioural mix model
// Revision 1.0
// ============================================================================
module tb_dac_sample_mixer;
  localparam int NS    = 2;
  localparam int W     = 16;
  localparam int DIV   = 16;
  localparam int STALE = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dac_sample_mixer_if #(.NUM_SRC(NS), .IN_WIDTH(W), .OUT_WIDTH(W)) bus ();

  dac_sample_mixer #(
    .NUM_SRC(NS), .IN_WIDTH(W), .OUT_WIDTH(W), .CLK_DIV(DIV), .STALE_TICKS(STALE)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         due;
    logic [15:0] l;
    logic [15:0] r;
    logic        clip;
  } exp_t;

  exp_t              exp_q[$];
  int                vectors     = 0;
  int                miscompares = 0;
  int                edges       = 0;
  int                m_cnt       = 0;
  int                ticks       = 0;
  int                cap_ep   [NS];
  logic signed [15:0] m_hold_l [NS];
  logic signed [15:0] m_hold_r [NS];
  logic [15:0]       last_l = '0;
  logic [15:0]       last_r = '0;
  bit                mon_on = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at edge %0d", tag, obs, exp, edges);
    end
  endtask

  function automatic logic [16:0] sat16(input int v);
    if (v > 32767)  return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  // Reference: latest captured value per source, aged in whole ticks since capture.
  always @(posedge clk) begin : p_model
    int sl, sr;
    logic [16:0] ol, orr;
    exp_t e;
    edges++;
    if (reset) begin
      m_cnt = 0;
      ticks = 0;
      exp_q.delete();
      last_l = '0;
      last_r = '0;
      for (int i = 0; i < NS; i++) begin
        m_hold_l[i] = '0;
        m_hold_r[i] = '0;
        cap_ep[i]   = -100;
      end
    end else begin
      if (m_cnt == DIV - 1) begin
        ticks++;
        sl = 0;
        sr = 0;
        for (int i = 0; i < NS; i++) begin
          if (bus.src_en[i] && ((ticks - 1 - cap_ep[i]) < STALE)) begin
            sl += (int'(m_hold_l[i]) >>> bus.src_atten[i*3 +: 3]);
            sr += (int'(m_hold_r[i]) >>> bus.src_atten[i*3 +: 3]);
          end
        end
        ol     = sat16(sl);
        orr    = sat16(sr);
        e.due  = edges + 3;
        e.l    = ol[15:0];
        e.r    = orr[15:0];
        e.clip = ol[16] | orr[16];
        exp_q.push_back(e);
      end
      for (int i = 0; i < NS; i++) begin
        if (bus.src_valid[i]) begin
          m_hold_l[i] = bus.src_l[i*16 +: 16];
          m_hold_r[i] = bus.src_r[i*16 +: 16];
          cap_ep[i]   = ticks;
        end
      end
      m_cnt = (m_cnt + 1) % DIV;
    end
  end

  always @(negedge clk) begin : p_monitor
    exp_t e;
    bit   due_now;
    if (mon_on) begin
      while (exp_q.size() > 0 && exp_q[0].due < edges) begin
        check_val("late_sample", edges, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      due_now = (exp_q.size() > 0) && (exp_q[0].due == edges);
      check_val("valid", {31'd0, bus.sample_valid}, {31'd0, due_now});
      if (due_now) begin
        e = exp_q.pop_front();
        check_val("mix_l", bus.sample_l, e.l);
        check_val("mix_r", bus.sample_r, e.r);
        check_val("clip", {31'd0, bus.clip}, {31'd0, e.clip});
        last_l = e.l;
        last_r = e.r;
      end else begin
        check_val("hold_l", bus.sample_l, last_l);
        check_val("hold_r", bus.sample_r, last_r);
        check_val("clip_idle", {31'd0, bus.clip}, 32'd0);
      end
    end
  end

  task automatic wait_phase(input int p);
    for (int k = 0; k < 2 * DIV; k++) begin
      @(negedge clk);
      if (m_cnt == p) return;
    end
    check_val("phase_timeout", m_cnt, p);
  endtask

  task automatic wait_sample(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.sample_valid) begin
        n = k;
        break;
      end
    end
    if (n == 0) check_val("sample_timeout", {31'd0, bus.sample_valid}, 32'd1);
  endtask

  task automatic load(input int i, input logic [15:0] l, input logic [15:0] r);
    bus.src_valid[i]     = 1'b1;
    bus.src_l[i*16 +: 16] = l;
    bus.src_r[i*16 +: 16] = r;
  endtask

  task automatic strobe();
    @(negedge clk);
    bus.src_valid = '0;
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 3))
      0:       return 16'h7000 | 16'($urandom_range(0, 16'h0FFF));
      1:       return 16'h8000 | 16'($urandom_range(0, 16'h0FFF));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin : p_stim
    int n;
    bus.src_valid = '0;
    bus.src_l     = '0;
    bus.src_r     = '0;
    bus.src_en    = 2'b11;
    bus.src_atten = '0;

    repeat (3) @(negedge clk);
    mon_on = 1'b1;
    reset  = 1'b0;

    // Idle after reset: silent pulses, first at edge 19, then every 16.
    wait_sample(n);
    check_val("first_pulse", n, 19);
    check_val("idle_l", bus.sample_l, 16'h0000);
    wait_sample(n);
    check_val("period", n, 16);

    wait_phase(4);
    load(0, 16'h1000, 16'h2000);
    load(1, 16'h0100, 16'hFF00);
    strobe();
    wait_sample(n);
    check_val("sum_l", bus.sample_l, 16'h1100);
    check_val("sum_r", bus.sample_r, 16'h1F00);
    check_val("sum_clip", {31'd0, bus.clip}, 32'd0);

    wait_phase(4);
    load(0, 16'h7000, 16'h0000);
    load(1, 16'h7000, 16'h0000);
    strobe();
    wait_sample(n);
    check_val("sat_pos_l", bus.sample_l, 16'h7FFF);
    check_val("sat_pos_clip", {31'd0, bus.clip}, 32'd1);

    wait_phase(4);
    load(0, 16'h9000, 16'h0000);
    load(1, 16'h9000, 16'h0000);
    strobe();
    wait_sample(n);
    check_val("sat_neg_l", bus.sample_l, 16'h8000);
    check_val("sat_neg_clip", {31'd0, bus.clip}, 32'd1);

    wait_phase(4);
    bus.src_en = 2'b01;
    load(0, 16'h7000, 16'h0000);
    load(1, 16'h7000, 16'h0000);
    strobe();
    wait_sample(n);
    check_val("en_mask_l", bus.sample_l, 16'h7000);
    check_val("en_mask_clip", {31'd0, bus.clip}, 32'd0);

    wait_phase(4);
    bus.src_atten = 6'b000_010;
    load(0, 16'h4000, 16'h0000);
    strobe();
    wait_sample(n);
    check_val("atten_pos", bus.sample_l, 16'h1000);
    wait_phase(4);
    load(0, 16'hC000, 16'h0000);
    strobe();
    wait_sample(n);
    check_val("atten_neg", bus.sample_l, 16'hF000);

    // One capture survives two ticks, then the source is muted.
    wait_phase(4);
    bus.src_atten = '0;
    load(0, 16'h0800, 16'h0000);
    strobe();
    wait_sample(n);
    check_val("stale_1", bus.sample_l, 16'h0800);
    wait_sample(n);
    check_val("stale_2", bus.sample_l, 16'h0800);
    wait_sample(n);
    check_val("stale_3", bus.sample_l, 16'h0000);

    wait_phase(4);
    load(0, 16'h0123, 16'h0000);
    strobe();
    wait_phase(DIV - 1);
    load(0, 16'h0456, 16'h0000);
    strobe();
    wait_sample(n);
    check_val("coinc_old", bus.sample_l, 16'h0123);
    wait_sample(n);
    check_val("coinc_new", bus.sample_l, 16'h0456);

    // Reset one cycle into the pass aborts it.
    wait_phase(4);
    load(0, 16'h0777, 16'h0000);
    strobe();
    wait_phase(0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_valid", {31'd0, bus.sample_valid}, 32'd0);
    check_val("abort_l", bus.sample_l, 16'h0000);
    wait_sample(n);
    check_val("resume_at", n, 19);
    wait_phase(4);
    load(0, 16'h0321, 16'h0000);
    strobe();
    wait_sample(n);
    check_val("resume_l", bus.sample_l, 16'h0321);

    bus.src_en = 2'b11;
    for (int c = 0; c < 150 * DIV; c++) begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 3) == 0) load(i, pick_val(), pick_val());
        else bus.src_valid[i] = 1'b0;
      end
      if (m_cnt == 6 && $urandom_range(0, 2) == 0) begin
        bus.src_en    = 2'($urandom);
        bus.src_atten = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      end
    end
    bus.src_valid = '0;
    wait_sample(n);
    @(negedge clk);
    check_val("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
